// File: rtl/rgb_pwm_driver.sv
// Three-channel PWM driver for the board RGB LED. Duty triplets arrive over a
// valid/ready handshake, are held in a pending buffer, and load only at the period wrap.
module rgb_pwm_driver #(
    parameter int WIDTH    = 8,
    parameter int PRESCALE = 64,
    parameter bit INVERT   = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] duty_r,
    input  logic [WIDTH-1:0] duty_g,
    input  logic [WIDTH-1:0] duty_b,
    input  logic             duty_valid,
    output logic             duty_ready,
    output logic             period_start,
    output logic             led0_r,
    output logic             led0_g,
    output logic             led0_b
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PW-1:0]          presc_reg;
    logic [PW-1:0]          presc_next;
    logic [WIDTH-1:0]       cnt_reg;
    logic [WIDTH-1:0]       cnt_next;
    logic                   pending_full_reg;
    logic                   pending_full_next;
    logic                   period_start_reg;
    logic                   tick;
    logic                   wrap;
    logic                   load;
    logic                   accept;
    logic [2:0][WIDTH-1:0]  duty_in;
    logic [2:0]             led_vec;

    assign tick       = (presc_reg == PW'(PRESCALE - 1));
    assign wrap       = tick && (cnt_reg == '1);
    assign presc_next = tick ? '0 : presc_reg + PW'(1);
    assign cnt_next   = tick ? cnt_reg + WIDTH'(1) : cnt_reg;

    // Load uses the pending state from the start of the cycle, so a triplet
    // accepted on the wrap cycle waits for the following wrap.
    assign load       = wrap && pending_full_reg;
    assign duty_ready = !pending_full_reg && !rst;
    assign accept     = duty_valid && duty_ready;
    assign duty_in    = {duty_b, duty_g, duty_r};

    always_comb begin
        pending_full_next = pending_full_reg;
        if (load)
            pending_full_next = 1'b0;
        if (accept)
            pending_full_next = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_reg        <= '0;
            cnt_reg          <= '0;
            pending_full_reg <= 1'b0;
            period_start_reg <= 1'b0;
        end else begin
            presc_reg        <= presc_next;
            cnt_reg          <= cnt_next;
            pending_full_reg <= pending_full_next;
            period_start_reg <= wrap;
        end
    end

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_chan
            logic [WIDTH-1:0] active_reg;
            logic [WIDTH-1:0] active_next;
            logic [WIDTH-1:0] pending_reg;
            logic             led_reg;

            assign active_next = load ? pending_reg : active_reg;

            // Compare against post-update cnt/active so the new duty is
            // visible from the very first cycle of the period.
            always_ff @(posedge clk) begin
                if (rst) begin
                    active_reg  <= '0;
                    pending_reg <= '0;
                    led_reg     <= INVERT;
                end else begin
                    active_reg <= active_next;
                    if (accept)
                        pending_reg <= duty_in[gi];
                    led_reg <= (cnt_next < active_next) ^ INVERT;
                end
            end

            assign led_vec[gi] = led_reg;
        end
    endgenerate

    assign period_start = period_start_reg;
    assign led0_r       = led_vec[0];
    assign led0_g       = led_vec[1];
    assign led0_b       = led_vec[2];

endmodule

// File: tb/tb_rgb_pwm_driver.sv
// Bench for rgb_pwm_driver (WIDTH=4, PRESCALE=2): directed table, corner sequences,
// random traffic, all checked each cycle against a period-level reference model.
module tb_rgb_pwm_driver;

    localparam int W      = 4;
    localparam int PS     = 2;
    localparam int PERIOD = PS * (1 << W);

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] duty_r = '0;
    logic [W-1:0] duty_g = '0;
    logic [W-1:0] duty_b = '0;
    logic         duty_valid = 1'b0;
    logic         duty_ready, period_start, led0_r, led0_g, led0_b;
    logic         i_ready, i_ps, i_r, i_g, i_b;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model state: cycles since reset release, active and pending duties
    int m_t = 0;
    bit m_full = 1'b0;
    int m_act[3] = '{0, 0, 0};
    int m_pend[3] = '{0, 0, 0};

    typedef struct {
        int r, g, b;
        int er, eg, eb;
    } vec_t;

    always #5 clk = ~clk;

    rgb_pwm_driver #(.WIDTH(W), .PRESCALE(PS), .INVERT(1'b0)) dut (
        .clk(clk), .rst(rst), .duty_r(duty_r), .duty_g(duty_g), .duty_b(duty_b),
        .duty_valid(duty_valid), .duty_ready(duty_ready), .period_start(period_start),
        .led0_r(led0_r), .led0_g(led0_g), .led0_b(led0_b)
    );

    rgb_pwm_driver #(.WIDTH(W), .PRESCALE(PS), .INVERT(1'b1)) dut_inv (
        .clk(clk), .rst(rst), .duty_r(duty_r), .duty_g(duty_g), .duty_b(duty_b),
        .duty_valid(duty_valid), .duty_ready(i_ready), .period_start(i_ps),
        .led0_r(i_r), .led0_g(i_g), .led0_b(i_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            if (tests_failed <= 40)
                $display("FAIL %s t=%0d: got %0d required %0d", name, m_t, act, exp);
        end
    endtask

    task automatic check_outputs();
        int  cnt;
        bit  ps;
        logic [2:0] led_exp;
        cnt = (m_t % PERIOD) / PS;
        ps  = (m_t != 0) && (m_t % PERIOD == 0);
        for (int i = 0; i < 3; i++)
            led_exp[i] = (cnt < m_act[i]);
        chk("duty_ready", {31'b0, duty_ready}, {31'b0, !m_full && !rst});
        chk("period_start", {31'b0, period_start}, {31'b0, ps});
        chk("led0_r", {31'b0, led0_r}, {31'b0, led_exp[0]});
        chk("led0_g", {31'b0, led0_g}, {31'b0, led_exp[1]});
        chk("led0_b", {31'b0, led0_b}, {31'b0, led_exp[2]});
        chk("inv_led", {29'b0, i_b, i_g, i_r}, {29'b0, ~led_exp});
        chk("inv_ready_ps", {30'b0, i_ready, i_ps}, {30'b0, !m_full && !rst, ps});
    endtask

    // One clock: model advances with the inputs as seen at the edge, then outputs checked.
    task automatic cycle();
        bit acc;
        int d[3];
        acc = duty_valid && !m_full && !rst;
        d = '{int'(duty_r), int'(duty_g), int'(duty_b)};
        @(posedge clk);
        if (rst) begin
            m_t = 0;
            m_full = 1'b0;
            m_act = '{0, 0, 0};
        end else begin
            m_t++;
            if (m_t % PERIOD == 0 && m_full) begin
                m_act = m_pend;
                m_full = 1'b0;
            end
            if (acc) begin
                m_pend = d;
                m_full = 1'b1;
            end
        end
        @(negedge clk);
        check_outputs();
    endtask

    task automatic send(input int r, input int g, input int b);
        bit acc;
        int guard = 0;
        duty_r = W'(r);
        duty_g = W'(g);
        duty_b = W'(b);
        duty_valid = 1'b1;
        do begin
            acc = !m_full && !rst;
            cycle();
            guard++;
        end while (!acc && guard < 200);
        if (!acc)
            chk("send_timeout", 32'd1, 32'd0);
        duty_valid = 1'b0;
    endtask

    task automatic count32(output int hr, output int hg, output int hb);
        hr = 0; hg = 0; hb = 0;
        for (int i = 0; i < PERIOD; i++) begin
            hr += int'(led0_r);
            hg += int'(led0_g);
            hb += int'(led0_b);
            cycle();
        end
    endtask

    // Move to the next period boundary (never the current one), then count high cycles.
    task automatic measure(output int hr, output int hg, output int hb);
        int guard = 0;
        cycle();
        while (!(m_t != 0 && m_t % PERIOD == 0) && guard < 100) begin
            cycle();
            guard++;
        end
        if (guard >= 100)
            chk("sync_timeout", 32'd1, 32'd0);
        count32(hr, hg, hb);
    endtask

    task automatic chk_counts(input string name, input int hr, input int hg, input int hb,
                              input int er, input int eg, input int eb);
        chk({name, "_r_high"}, hr, er);
        chk({name, "_g_high"}, hg, eg);
        chk({name, "_b_high"}, hb, eb);
    endtask

    initial begin
        vec_t vecs[5];
        int hr, hg, hb;

        vecs[0] = '{r: 4,  g: 8,  b: 15, er: 8,  eg: 16, eb: 30};
        vecs[1] = '{r: 0,  g: 0,  b: 0,  er: 0,  eg: 0,  eb: 0};
        vecs[2] = '{r: 1,  g: 15, b: 7,  er: 2,  eg: 30, eb: 14};
        vecs[3] = '{r: 15, g: 0,  b: 2,  er: 30, eg: 0,  eb: 4};
        vecs[4] = '{r: 12, g: 3,  b: 9,  er: 24, eg: 6,  eb: 18};

        // Reset held 3 cycles, then first period boundary 32 clk after release
        rst = 1'b1;
        repeat (3) cycle();
        rst = 1'b0;
        repeat (PERIOD) cycle();
        chk("first_period_start", {31'b0, period_start}, 32'd1);
        $display("[TB] reset and first period_start checked at t=%0d", m_t);

        foreach (vecs[i]) begin
            send(vecs[i].r, vecs[i].g, vecs[i].b);
            measure(hr, hg, hb);
            chk_counts("vec", hr, hg, hb, vecs[i].er, vecs[i].eg, vecs[i].eb);
            count32(hr, hg, hb);
            chk_counts("vec_steady", hr, hg, hb, vecs[i].er, vecs[i].eg, vecs[i].eb);
            $display("[TB] vec %0d duty=(%0d,%0d,%0d) high=(%0d,%0d,%0d)",
                     i, vecs[i].r, vecs[i].g, vecs[i].b, hr, hg, hb);
        end

        // All-zero duty across three periods
        send(0, 0, 0);
        for (int p = 0; p < 3; p++) begin
            measure(hr, hg, hb);
            chk_counts("zero", hr, hg, hb, 0, 0, 0);
        end
        $display("[TB] zero duty over 3 periods checked");

        // Back-to-back triplets: second held until wrap, applies the period after
        send(3, 5, 7);
        send(9, 1, 12);
        measure(hr, hg, hb);
        chk_counts("backpressure_2nd", hr, hg, hb, 18, 2, 24);
        $display("[TB] backpressure second triplet high=(%0d,%0d,%0d)", hr, hg, hb);

        // Triplet accepted exactly on the wrap cycle loads one period later
        send(2, 2, 2);
        measure(hr, hg, hb);
        while (m_t % PERIOD != PERIOD - 1)
            cycle();
        send(6, 6, 6);
        count32(hr, hg, hb);
        chk_counts("wrap_accept_old", hr, hg, hb, 4, 4, 4);
        count32(hr, hg, hb);
        chk_counts("wrap_accept_new", hr, hg, hb, 12, 12, 12);
        $display("[TB] accept-on-wrap old=4 new=(%0d,%0d,%0d)", hr, hg, hb);

        // Reset mid-period with a pending triplet: everything drops to zero duty
        send(10, 10, 10);
        measure(hr, hg, hb);
        send(5, 5, 5);
        while (m_t % PERIOD != 10)
            cycle();
        rst = 1'b1;
        cycle();
        chk("rst_led_r", {31'b0, led0_r}, 32'd0);
        cycle();
        rst = 1'b0;
        cycle();
        chk("rst_ready_after", {31'b0, duty_ready}, 32'd1);
        for (int p = 0; p < 2; p++) begin
            measure(hr, hg, hb);
            chk_counts("after_rst", hr, hg, hb, 0, 0, 0);
        end
        $display("[TB] mid-period reset with pending checked");

        // Random traffic, including occasional resets
        for (int it = 0; it < 40; it++) begin
            int idle;
            idle = $urandom_range(0, 20);
            repeat (idle) cycle();
            if ($urandom_range(0, 9) == 0) begin
                rst = 1'b1;
                repeat ($urandom_range(1, 3)) cycle();
                rst = 1'b0;
            end else begin
                send($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15));
            end
            $display("[TB] random step %0d t=%0d pend_full=%0d active=(%0d,%0d,%0d)",
                     it, m_t, m_full, m_act[0], m_act[1], m_act[2]);
        end
        repeat (2 * PERIOD) cycle();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, t=%0d", m_t);
        $fatal(1, "watchdog expired");
    end

endmodule
